// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX slot bus bridge.
package msx_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } bus_state_t;

    // Value returned to the CPU when nothing drives read data
    localparam logic [7:0] BUS_FLOAT = 8'hFF;

    // Cycle kinds as reported on bus_memory
    localparam logic KIND_IO  = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Bit positions of the strobes inside the synchroniser vector
    localparam int STB_SLTSL = 0;
    localparam int STB_MERQ  = 1;
    localparam int STB_IORQ  = 2;
    localparam int STB_RD    = 3;
    localparam int STB_WR    = 4;
    localparam int STB_COUNT = 5;

    // True when port lies in the window [base, base+ports) taken modulo 256
    function automatic logic io_hit(input logic [7:0] port,
                                    input logic [7:0] base,
                                    input logic [4:0] ports);
        logic [7:0] offset;
        offset = port - base;
        return ({1'b0, offset} < {4'b0000, ports});
    endfunction

endpackage

// File: rtl/msx_bus_sync.sv
// Multi-flop synchroniser with fall/rise pulses for active-low strobes.
// Edge pulses are held off until the chain has been refilled after reset so
// that a strobe still low when reset releases is not seen as a new edge.
module msx_bus_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] chain_r [STAGES];
    logic [WIDTH-1:0] prev_r;
    logic [STAGES:0]  settle_r;

    // Synchroniser chain, previous-value register and post-reset settle shifter
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_r[i] <= {WIDTH{1'b1}};
            end
            prev_r   <= {WIDTH{1'b1}};
            settle_r <= {(STAGES+1){1'b0}};
        end else begin
            chain_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
            prev_r   <= chain_r[STAGES-1];
            settle_r <= {settle_r[STAGES-1:0], 1'b1};
        end
    end

    assign q    = chain_r[STAGES-1];
    assign fall = {WIDTH{settle_r[STAGES]}} & prev_r & ~q;
    assign rise = {WIDTH{settle_r[STAGES]}} & ~prev_r & q;

endmodule

// File: rtl/msx_slot_bus_bridge.sv
// Bridge from the asynchronous MSX slot bus to the internal req/ack bus:
// strobe synchronisation, memory/I-O window decode, /WAIT with timeout and
// read-data direction control.
module msx_slot_bus_bridge
    import msx_bus_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] IO_BASE      = 8'h10,
    parameter int         IO_PORTS     = 4,
    parameter bit         WAIT_EN      = 1'b1,
    parameter int         WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        n_tsltsl,
    input  logic        n_tmerq,
    input  logic        n_tiorq,
    input  logic        n_trd,
    input  logic        n_twr,
    input  logic [15:0] ta,
    input  logic [7:0]  td_in,
    output logic [7:0]  td_out,
    output logic        td_oe,
    output logic        twait,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_memory,
    output logic        bus_write,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_en,
    output logic        timeout
);

    localparam logic [4:0]  IO_PORTS_W = 5'(IO_PORTS);
    localparam logic [15:0] TMO_LAST   = 16'(WAIT_TIMEOUT - 1);

    logic [STB_COUNT-1:0] raw_s, q_s, fall_s, rise_s;
    logic mem_sel_s, io_sel_s, start_s, hold_sel_s, unused_s;

    bus_state_t  state_r, state_n;
    logic [15:0] cnt_r, cnt_n;
    logic        gone_r, gone_n;
    logic [7:0]  td_out_r, td_out_n;
    logic        td_oe_r, td_oe_n;
    logic        twait_r, twait_n;
    logic        valid_r, valid_n;
    logic        mem_r, mem_n;
    logic        write_r, write_n;
    logic [15:0] addr_r, addr_n;
    logic [7:0]  wdata_r, wdata_n;
    logic        timeout_r, timeout_n;

    assign raw_s = {n_twr, n_trd, n_tiorq, n_tmerq, n_tsltsl};

    msx_bus_sync #(
        .WIDTH  (STB_COUNT),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (raw_s),
        .q       (q_s),
        .fall    (fall_s),
        .rise    (rise_s)
    );

    // Only the /RD and /WR edges start or abort cycles
    assign unused_s = ^{fall_s[STB_IORQ], fall_s[STB_MERQ], fall_s[STB_SLTSL],
                        rise_s[STB_IORQ], rise_s[STB_MERQ], rise_s[STB_SLTSL]};

    assign mem_sel_s  = ~q_s[STB_SLTSL] & ~q_s[STB_MERQ];
    assign io_sel_s   = ~q_s[STB_IORQ] & q_s[STB_MERQ] & io_hit(ta[7:0], IO_BASE, IO_PORTS_W);
    assign start_s    = (fall_s[STB_RD] | fall_s[STB_WR]) & (mem_sel_s | io_sel_s);
    assign hold_sel_s = mem_r ? mem_sel_s : io_sel_s;

    // Next-state and next-output decode for the bridge FSM
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        gone_n    = gone_r;
        td_out_n  = td_out_r;
        td_oe_n   = td_oe_r;
        twait_n   = twait_r;
        valid_n   = valid_r;
        mem_n     = mem_r;
        write_n   = write_r;
        addr_n    = addr_r;
        wdata_n   = wdata_r;
        timeout_n = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    mem_n   = mem_sel_s ? KIND_MEM : KIND_IO;
                    write_n = ~fall_s[STB_RD];
                    addr_n  = mem_sel_s ? ta : {8'h00, ta[7:0]};
                    wdata_n = td_in;
                    valid_n = 1'b1;
                    twait_n = WAIT_EN;
                    cnt_n   = 16'h0000;
                    gone_n  = 1'b0;
                    td_oe_n = 1'b0;
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_REQ: begin
                cnt_n  = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
                gone_n = gone_r | (write_r ? rise_s[STB_WR] : rise_s[STB_RD]);
                if (bus_ready) begin
                    if (!write_r) begin
                        td_out_n = bus_rdata_en ? bus_rdata : BUS_FLOAT;
                    end else begin
                        td_out_n = td_out_r;
                    end
                    valid_n = 1'b0;
                    twait_n = 1'b0;
                    td_oe_n = ~write_r & ~q_s[STB_RD] & hold_sel_s & ~gone_n;
                    state_n = ST_HOLD;
                end else if (cnt_r == TMO_LAST) begin
                    valid_n   = 1'b0;
                    twait_n   = 1'b0;
                    td_out_n  = BUS_FLOAT;
                    timeout_n = 1'b1;
                    td_oe_n   = ~write_r & ~q_s[STB_RD] & hold_sel_s & ~gone_n;
                    state_n   = ST_HOLD;
                end else begin
                    state_n = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (q_s[STB_RD] & q_s[STB_WR]) begin
                    td_oe_n = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    td_oe_n = ~write_r & ~q_s[STB_RD] & hold_sel_s & ~gone_r;
                    state_n = ST_HOLD;
                end
            end

            default: begin
                valid_n = 1'b0;
                twait_n = 1'b0;
                td_oe_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered output update
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'h0000;
            gone_r    <= 1'b0;
            td_out_r  <= 8'h00;
            td_oe_r   <= 1'b0;
            twait_r   <= 1'b0;
            valid_r   <= 1'b0;
            mem_r     <= 1'b0;
            write_r   <= 1'b0;
            addr_r    <= 16'h0000;
            wdata_r   <= 8'h00;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            gone_r    <= gone_n;
            td_out_r  <= td_out_n;
            td_oe_r   <= td_oe_n;
            twait_r   <= twait_n;
            valid_r   <= valid_n;
            mem_r     <= mem_n;
            write_r   <= write_n;
            addr_r    <= addr_n;
            wdata_r   <= wdata_n;
            timeout_r <= timeout_n;
        end
    end

    assign td_out      = td_out_r;
    assign td_oe       = td_oe_r;
    assign twait       = twait_r;
    assign bus_valid   = valid_r;
    assign bus_memory  = mem_r;
    assign bus_write   = write_r;
    assign bus_address = addr_r;
    assign bus_wdata   = wdata_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_msx_slot_bus_bridge.sv
// Directed bench for msx_slot_bus_bridge. Three instances share the slot
// inputs: u_a default, u_b with WAIT_EN=0, u_c with a wrapping I/O window.
module tb_msx_slot_bus_bridge;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic n_tsltsl = 1'b1, n_tmerq = 1'b1, n_tiorq = 1'b1, n_trd = 1'b1, n_twr = 1'b1;
    logic [15:0] ta = 16'h0000;
    logic [7:0]  td_in = 8'h00;
    logic        bus_ready = 1'b0;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_rdata_en = 1'b0;

    logic [7:0]  a_td_out, a_wdata, b_td_out, b_wdata, c_td_out, c_wdata;
    logic        a_td_oe, a_twait, a_valid, a_memory, a_write, a_timeout;
    logic        b_td_oe, b_twait, b_valid, b_memory, b_write, b_timeout;
    logic        c_td_oe, c_twait, c_valid, c_memory, c_write, c_timeout;
    logic [15:0] a_address, b_address, c_address;

    int errors = 0;
    int checks = 0;
    int n;
    logic seen;

    always #5 clk = ~clk;

    msx_slot_bus_bridge u_a (
        .clk(clk), .n_reset(n_reset), .n_tsltsl(n_tsltsl), .n_tmerq(n_tmerq),
        .n_tiorq(n_tiorq), .n_trd(n_trd), .n_twr(n_twr), .ta(ta), .td_in(td_in),
        .td_out(a_td_out), .td_oe(a_td_oe), .twait(a_twait), .bus_valid(a_valid),
        .bus_ready(bus_ready), .bus_memory(a_memory), .bus_write(a_write),
        .bus_address(a_address), .bus_wdata(a_wdata), .bus_rdata(bus_rdata),
        .bus_rdata_en(bus_rdata_en), .timeout(a_timeout)
    );

    msx_slot_bus_bridge #(.WAIT_EN(1'b0)) u_b (
        .clk(clk), .n_reset(n_reset), .n_tsltsl(n_tsltsl), .n_tmerq(n_tmerq),
        .n_tiorq(n_tiorq), .n_trd(n_trd), .n_twr(n_twr), .ta(ta), .td_in(td_in),
        .td_out(b_td_out), .td_oe(b_td_oe), .twait(b_twait), .bus_valid(b_valid),
        .bus_ready(bus_ready), .bus_memory(b_memory), .bus_write(b_write),
        .bus_address(b_address), .bus_wdata(b_wdata), .bus_rdata(bus_rdata),
        .bus_rdata_en(bus_rdata_en), .timeout(b_timeout)
    );

    msx_slot_bus_bridge #(.IO_BASE(8'hFE), .IO_PORTS(4)) u_c (
        .clk(clk), .n_reset(n_reset), .n_tsltsl(n_tsltsl), .n_tmerq(n_tmerq),
        .n_tiorq(n_tiorq), .n_trd(n_trd), .n_twr(n_twr), .ta(ta), .td_in(td_in),
        .td_out(c_td_out), .td_oe(c_td_oe), .twait(c_twait), .bus_valid(c_valid),
        .bus_ready(bus_ready), .bus_memory(c_memory), .bus_write(c_write),
        .bus_address(c_address), .bus_wdata(c_wdata), .bus_rdata(bus_rdata),
        .bus_rdata_en(bus_rdata_en), .timeout(c_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) tick();
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_td_out"}, 32'(a_td_out), 32'h00);
        check({tag, "_td_oe"},  32'(a_td_oe), 32'h0);
        check({tag, "_twait"},  32'(a_twait), 32'h0);
        check({tag, "_valid"},  32'(a_valid), 32'h0);
        check({tag, "_memory"}, 32'(a_memory), 32'h0);
        check({tag, "_write"},  32'(a_write), 32'h0);
        check({tag, "_addr"},   32'(a_address), 32'h0000);
        check({tag, "_wdata"},  32'(a_wdata), 32'h00);
        check({tag, "_tmo"},    32'(a_timeout), 32'h0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        check_reset_a("rst");
        n_reset = 1'b1;
        idle(6);

        // Memory read at 4000, ready 3 clocks after valid
        ta = 16'h4000; n_tsltsl = 1'b0; n_tmerq = 1'b0; n_trd = 1'b0;
        idle(2);
        check("rd_lat2_valid", 32'(a_valid), 32'h0);
        tick();
        check("rd_valid", 32'(a_valid), 32'h1);
        check("rd_memory", 32'(a_memory), 32'h1);
        check("rd_write", 32'(a_write), 32'h0);
        check("rd_addr", 32'(a_address), 32'h4000);
        check("rd_twait", 32'(a_twait), 32'h1);
        idle(2);
        check("rd_twait_held", 32'(a_twait), 32'h1);
        check("rd_valid_held", 32'(a_valid), 32'h1);
        bus_ready = 1'b1; bus_rdata = 8'hA5; bus_rdata_en = 1'b1;
        tick();
        bus_ready = 1'b0;
        check("rd_valid_drop", 32'(a_valid), 32'h0);
        check("rd_twait_drop", 32'(a_twait), 32'h0);
        check("rd_td_oe", 32'(a_td_oe), 32'h1);
        check("rd_td_out", 32'(a_td_out), 32'hA5);
        idle(2);
        check("rd_td_oe_hold", 32'(a_td_oe), 32'h1);
        n_trd = 1'b1;
        idle(2);
        check("rd_td_oe_sync", 32'(a_td_oe), 32'h1);
        tick();
        check("rd_td_oe_off", 32'(a_td_oe), 32'h0);
        n_tsltsl = 1'b1; n_tmerq = 1'b1;
        idle(10);

        // Memory read with bus_rdata_en=0 returns the float value
        n_tsltsl = 1'b0; n_tmerq = 1'b0; n_trd = 1'b0;
        idle(3);
        check("fl_valid", 32'(a_valid), 32'h1);
        bus_ready = 1'b1; bus_rdata = 8'h5A; bus_rdata_en = 1'b0;
        tick();
        bus_ready = 1'b0;
        check("fl_td_out", 32'(a_td_out), 32'hFF);
        n_trd = 1'b1; n_tsltsl = 1'b1; n_tmerq = 1'b1;
        idle(10);

        // I/O write to port 12 inside the 10..13 window
        ta = 16'h0012; td_in = 8'h3C; n_tiorq = 1'b0; n_twr = 1'b0;
        idle(3);
        check("iow_valid", 32'(a_valid), 32'h1);
        check("iow_memory", 32'(a_memory), 32'h0);
        check("iow_write", 32'(a_write), 32'h1);
        check("iow_addr", 32'(a_address), 32'h0012);
        check("iow_wdata", 32'(a_wdata), 32'h3C);
        check("iow_c_ignored", 32'(c_valid), 32'h0);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        check("iow_valid_drop", 32'(a_valid), 32'h0);
        check("iow_td_oe", 32'(a_td_oe), 32'h0);
        n_twr = 1'b1; n_tiorq = 1'b1;
        idle(10);

        // I/O write to port 14 is outside the window
        ta = 16'h0014; n_tiorq = 1'b0; n_twr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | a_valid | a_twait;
        end
        check("io_miss", 32'(seen), 32'h0);
        n_twr = 1'b1; n_tiorq = 1'b1;
        idle(6);

        // Port 01 hits the wrapped FE..01 window of u_c only
        ta = 16'h0001; td_in = 8'h55; n_tiorq = 1'b0; n_twr = 1'b0;
        idle(3);
        check("wrap_valid", 32'(c_valid), 32'h1);
        check("wrap_addr", 32'(c_address), 32'h0001);
        check("wrap_wdata", 32'(c_wdata), 32'h55);
        check("wrap_a_ignored", 32'(a_valid), 32'h0);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        check("wrap_valid_drop", 32'(c_valid), 32'h0);
        n_twr = 1'b1; n_tiorq = 1'b1;
        idle(10);

        // WAIT_EN=0: /RD released before bus_ready
        ta = 16'h4000; n_tsltsl = 1'b0; n_tmerq = 1'b0; n_trd = 1'b0;
        idle(3);
        check("nw_valid", 32'(b_valid), 32'h1);
        check("nw_twait", 32'(b_twait), 32'h0);
        n_trd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | b_td_oe;
        end
        bus_ready = 1'b1; bus_rdata = 8'h77; bus_rdata_en = 1'b1;
        tick();
        bus_ready = 1'b0;
        seen = seen | b_td_oe;
        check("nw_valid_drop", 32'(b_valid), 32'h0);
        check("nw_td_out", 32'(b_td_out), 32'h77);
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | b_td_oe;
        end
        check("nw_td_oe_never", 32'(seen), 32'h0);
        n_tsltsl = 1'b1; n_tmerq = 1'b1;
        idle(10);

        // Timeout: bus_ready never arrives
        n_tsltsl = 1'b0; n_tmerq = 1'b0; n_trd = 1'b0;
        idle(3);
        check("tmo_valid", 32'(a_valid), 32'h1);
        n = 0;
        while (a_valid && n < 400) begin
            n++;
            tick();
        end
        check("tmo_len", 32'(n), 32'd255);
        check("tmo_pulse", 32'(a_timeout), 32'h1);
        check("tmo_td_out", 32'(a_td_out), 32'hFF);
        check("tmo_twait", 32'(a_twait), 32'h0);
        tick();
        check("tmo_pulse_end", 32'(a_timeout), 32'h0);
        n_trd = 1'b1; n_tsltsl = 1'b1; n_tmerq = 1'b1;
        idle(10);

        // Asynchronous reset while a request is outstanding
        n_tsltsl = 1'b0; n_tmerq = 1'b0; n_trd = 1'b0;
        idle(3);
        check("ar_valid", 32'(a_valid), 32'h1);
        #2;
        n_reset = 1'b0;
        #1;
        check_reset_a("ar");
        #1;
        n_reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | a_valid;
        end
        check("ar_no_replay", 32'(seen), 32'h0);
        n_trd = 1'b1;
        idle(3);
        ta = 16'h4001; n_trd = 1'b0;
        idle(3);
        check("ar_rd_valid", 32'(a_valid), 32'h1);
        check("ar_rd_addr", 32'(a_address), 32'h4001);
        bus_ready = 1'b1; bus_rdata = 8'hC3; bus_rdata_en = 1'b1;
        tick();
        bus_ready = 1'b0;
        check("ar_rd_td_out", 32'(a_td_out), 32'hC3);
        check("ar_rd_td_oe", 32'(a_td_oe), 32'h1);
        n_trd = 1'b1; n_tsltsl = 1'b1; n_tmerq = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msx_slot_bus_bridge.md
# msx_slot_bus_bridge

Synthesisable, parametrised bridge between the asynchronous MSX cartridge slot bus (/SLTSL, /MERQ, /IORQ, /RD, /WR, A[15:0], D[7:0]) and the internal single-clock request/acknowledge bus of the cartridge top level. It sits directly behind the top-level pins and replaces ad-hoc per-device strobe decoding. It adds synchronisation, memory and I/O window decode, /WAIT insertion with a timeout, and read-data direction control.

## Interface
- SYNC_STAGES, 2: synchroniser depth on the control strobes (2..4).
- IO_BASE, 8'h10: first I/O port claimed.
- IO_PORTS, 4: number of consecutive I/O ports claimed (1..16); the window wraps modulo 256.
- WAIT_EN, 1: 1 = assert /WAIT while a request is outstanding.
- WAIT_TIMEOUT, 255: clocks in ST_REQ before the request is abandoned (1..65535).

Ports:
- clk  in  1  internal clock (21.47727 MHz)
- n_reset  in  1  asynchronous active-low reset
- n_tsltsl, n_tmerq, n_tiorq, n_trd, n_twr  in  1 each  raw slot strobes, asynchronous
- ta  in  16  slot address
- td_in  in  8  slot data, CPU to cartridge
- td_out  out  8  slot data, cartridge to CPU
- td_oe  out  1  1 = cartridge drives D (feeds tdir)
- twait  out  1  1 = pull /WAIT low
- bus_valid  out  1  request pending
- bus_ready  in  1  request accepted or completed this clock
- bus_memory  out  1  1 = memory cycle, 0 = I/O cycle
- bus_write  out  1  1 = write
- bus_address  out  16  latched address (upper 8 bits are 0 for I/O)
- bus_wdata  out  8  latched write data
- bus_rdata  in  8  read data, valid with bus_ready
- bus_rdata_en  in  1  1 = bus_rdata is driven; 0 = return 8'hFF
- timeout  out  1  one-clock pulse when a request is abandoned

## Operation
- Strobes pass through SYNC_STAGES flops and are then edge-detected. ta and td_in are sampled on the clock that detects the edge; the strobe has been low for at least SYNC_STAGES clocks by then.
- Memory select is: synced /SLTSL=0 and /MERQ=0.
- I/O select is: synced /IORQ=0, /MERQ=1, and ((ta[7:0]-IO_BASE) mod 256) < IO_PORTS.
- A cycle starts on a falling edge of synced /RD or /WR while a select is true. If /RD and /WR fall together, the read wins.
- FSM states:
  - ST_IDLE: on start, latch kind, direction, address and data; set bus_valid=1; set twait=WAIT_EN; go to ST_REQ.
  - ST_REQ: hold all bus_* outputs stable. The timeout counter increments.
    - On bus_ready: for a read, latch td_out = bus_rdata_en ? bus_rdata : 8'hFF. Clear bus_valid and twait. Go to ST_HOLD.
    - When the counter reaches WAIT_TIMEOUT without bus_ready: clear bus_valid and twait, set td_out=8'hFF, pulse timeout, go to ST_HOLD.
  - ST_HOLD: td_oe=1 while the cycle is a read and synced /RD=0 and select is still true. When both synced /RD and /WR are high, clear td_oe and go to ST_IDLE.
- If the strobe rises while in ST_REQ (possible with WAIT_EN=0), the request still completes internally. td_oe is never raised for that cycle.
- New start edges seen outside ST_IDLE are ignored.
- The timeout counter is cleared on entry to ST_REQ and saturates.

## Timing
- Reset values: td_out=8'h00, td_oe=0, twait=0, bus_valid=0, bus_memory=0, bus_write=0, bus_address=0, bus_wdata=0, timeout=0, state=ST_IDLE.
- An asynchronous reset mid-transaction returns every output to its reset value at once. No request is replayed after reset.
- Raw strobe falling edge to bus_valid=1: SYNC_STAGES+1 clocks (3 at the default).
- bus_ready to td_oe=1 and twait=0: 1 clock. bus_valid drops on that same clock.
- bus_ready may be high on the first ST_REQ clock. The minimum request is then 1 clock.
- Synced /RD rising to td_oe=0: 1 clock.
- Timeout: bus_valid is high for exactly WAIT_TIMEOUT clocks, and the timeout pulse comes on the following clock.

## Structure
- Package msx_bus_pkg: the state enum (ST_IDLE, ST_REQ, ST_HOLD), localparam BUS_FLOAT = 8'hFF, and the cycle-kind constants.
- Sub-module msx_bus_sync, parametrised by WIDTH and STAGES. It contains the synchroniser flops plus fall/rise pulse outputs and is instantiated once for the 5 strobes.

## Test plan
- Memory read at 16'h4000; bus_ready 3 clocks after bus_valid with bus_rdata=8'hA5 and bus_rdata_en=1 -> bus_memory=1, bus_address=16'h4000; twait high for 3 clocks then low; td_out=8'hA5 with td_oe=1 until /RD rises.
- I/O write to port 8'h12 with data 8'h3C (IO_BASE=8'h10, IO_PORTS=4) -> bus_memory=0, bus_write=1, bus_address=16'h0012, bus_wdata=8'h3C; td_oe stays 0.
- I/O write to port 8'h14 -> bus_valid never rises and twait stays 0. Repeat with IO_BASE=8'hFE, IO_PORTS=4, port 8'h01 -> accepted (window wrap).
- Memory read with bus_ready held low and WAIT_TIMEOUT=255 -> bus_valid high for 255 clocks, then a one-clock timeout pulse, td_out=8'hFF, twait=0.
- Memory read with bus_rdata_en=0 -> td_out=8'hFF.
- With WAIT_EN=0, /RD released before bus_ready -> the request completes and td_oe never rises. Separately, n_reset pulsed during ST_REQ -> all outputs at reset values on the next sample, and the following read at 16'h4001 completes normally.
